// File: rtl/csi2_data_types_pkg.sv
// Shared CSI-2 data-path constants, types and the RAW10 group unpack helper.
package csi2_data_types_pkg;

    localparam int RAW10_GROUP_BYTES  = 5;
    localparam int RAW10_PX_PER_GROUP = 4;

    typedef logic [9:0] raw10_px_t;
    typedef raw10_px_t [RAW10_PX_PER_GROUP-1:0] raw10_quad_t;

    // Bytes 0..3 carry pixel MSBs, byte 4 packs the 2-bit LSBs of all four.
    function automatic raw10_quad_t raw10_unpack(input logic [39:0] grp);
        raw10_quad_t px;
        for (int k = 0; k < RAW10_PX_PER_GROUP; k++) begin
            px[k] = {grp[8*k +: 8], grp[32 + 2*k +: 2]};
        end
        return px;
    endfunction

endpackage

// File: rtl/csi2_byte_gearbox.sv
// 4-byte-in / 5-byte-out byte buffer with fill count.
// Byte 0 of the buffer is the oldest; unused bytes are always kept zero.
module csi2_byte_gearbox
    import csi2_data_types_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] in_data,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    output logic [3:0]  cnt,
    output logic [39:0] grp
);

    localparam logic [3:0] GRP = 4'(RAW10_GROUP_BYTES);

    logic [63:0] data_q;
    logic [63:0] rem;
    logic [63:0] ins;
    logic [3:0]  base;

    // Zero-filled shift on pop keeps OR-ing in new bytes safe.
    always_comb begin
        rem  = pop ? (data_q >> (8 * RAW10_GROUP_BYTES)) : data_q;
        base = pop ? (cnt - GRP) : cnt;
        ins  = {32'd0, in_data} << {base, 3'b000};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt    <= '0;
        end else if (flush) begin
            data_q <= '0;
            cnt    <= '0;
        end else begin
            data_q <= push ? (rem | ins) : rem;
            cnt    <= base + (push ? 4'd4 : 4'd0);
        end
    end

    assign grp = data_q[39:0];

endmodule

// File: rtl/csi2_raw10_unpacker.sv
// RAW10 payload unpacker: 32-bit CSI-2 payload words in, 4-pixel beats out.
// Line end, SOF and EOF are re-timed onto the pixel stream.
module csi2_raw10_unpacker
    import csi2_data_types_pkg::*;
#(
    parameter int PX_OUT_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           pkt_i_tdata,
    input  logic                  pkt_i_tvalid,
    input  logic                  pkt_i_tlast,
    output logic                  pkt_i_tready,
    input  logic                  frame_start_i,
    input  logic                  frame_end_i,
    output logic [4*PX_OUT_W-1:0] px_o_tdata,
    output logic                  px_o_tvalid,
    input  logic                  px_o_tready,
    output logic                  px_o_tlast,
    output logic                  px_o_tuser,
    output logic                  frame_end_o,
    output logic                  short_line_o
);

    localparam logic [3:0] GRP = 4'(RAW10_GROUP_BYTES);

    logic [3:0]  cnt;
    logic [3:0]  cnt_after;
    logic [39:0] grp;
    logic        run_q;
    logic        last_pend_q;
    logic        sof_pend_q;
    logic        eof_pend_q;
    logic        pop;
    logic        accept;
    logic        line_done;
    logic        short_now;
    logic        flush;
    logic        eof_fire;
    raw10_quad_t quad;
    logic [4*PX_OUT_W-1:0] beat;

    assign pop          = (cnt >= GRP) && (!px_o_tvalid || px_o_tready);
    assign pkt_i_tready = run_q && !last_pend_q && (cnt <= 4'd4 || pop);
    assign accept       = pkt_i_tvalid && pkt_i_tready;
    assign cnt_after    = cnt - (pop ? GRP : 4'd0)
                        + (accept ? 4'd4 : 4'd0);

    // The pop that coincides with taking the tlast word can also be the
    // final group when fewer than a group's worth of bytes remain after it.
    assign line_done = pop && (cnt_after < GRP)
                     && (last_pend_q || (accept && pkt_i_tlast));
    assign short_now = last_pend_q && (cnt < GRP);
    assign flush     = line_done || short_now;
    assign eof_fire  = eof_pend_q && (cnt == 4'd0)
                     && !last_pend_q && !px_o_tvalid;

    csi2_byte_gearbox u_gearbox (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_data (pkt_i_tdata),
        .push    (accept),
        .pop     (pop),
        .flush   (flush),
        .cnt     (cnt),
        .grp     (grp)
    );

    always_comb begin
        quad = raw10_unpack(grp);
        beat = '0;
        for (int k = 0; k < RAW10_PX_PER_GROUP; k++) begin
            beat[k*PX_OUT_W +: PX_OUT_W] =
                PX_OUT_W'(quad[k]) << (PX_OUT_W - 10);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q        <= 1'b0;
            last_pend_q  <= 1'b0;
            sof_pend_q   <= 1'b0;
            eof_pend_q   <= 1'b0;
            frame_end_o  <= 1'b0;
            short_line_o <= 1'b0;
            px_o_tdata   <= '0;
            px_o_tvalid  <= 1'b0;
            px_o_tlast   <= 1'b0;
            px_o_tuser   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                last_pend_q <= 1'b0;
            end else if (accept && pkt_i_tlast) begin
                last_pend_q <= 1'b1;
            end
            sof_pend_q   <= frame_start_i || (sof_pend_q && !pop);
            eof_pend_q   <= frame_end_i || (eof_pend_q && !eof_fire);
            frame_end_o  <= eof_fire;
            short_line_o <= short_now;
            if (pop) begin
                px_o_tdata  <= beat;
                px_o_tvalid <= 1'b1;
                px_o_tlast  <= line_done;
                px_o_tuser  <= sof_pend_q;
            end else if (px_o_tready) begin
                px_o_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/csi2_raw10_unpacker.md
Name: csi2_raw10_unpacker

Overview:
Sits directly downstream of the CSI-2 packet handler and consumes its payload stream: 32-bit words of RAW10 long-packet payload, little-endian byte order, with tlast on the final word.
It unpacks every 5-byte RAW10 group into 4 pixels, drops residual bytes (CRC or padding) at line end, and emits one 4-pixel beat per group.
Frame start and end pulses from the packet handler are re-timed to the pixel stream: SOF is carried as tuser on the first beat, and EOF is signalled after the pipeline drains.

Parameters:
PX_OUT_W, 10, output pixel width (≥10); each pixel is left-aligned and the unused LSBs are zero-filled.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
pkt_i_tdata  in  32  payload bytes; byte k = tdata[8k+7:8k], byte 0 is oldest
pkt_i_tvalid  in  1  input valid
pkt_i_tlast  in  1  last payload word of a line
pkt_i_tready  out  1  input ready
frame_start_i  in  1  1-cycle frame start pulse
frame_end_i  in  1  1-cycle frame end pulse
px_o_tdata  out  4*PX_OUT_W  pixels {P3,P2,P1,P0}, P0 at LSB
px_o_tvalid  out  1  output valid
px_o_tready  in  1  output ready
px_o_tlast  out  1  last beat of the line
px_o_tuser  out  1  first beat of the frame (SOF)
frame_end_o  out  1  1-cycle EOF pulse, issued after drain
short_line_o  out  1  1-cycle pulse: a line ended with no complete group

Behaviour:
- State:
  - 8-byte buffer buf, byte 0 oldest.
  - cnt, 0..8 valid bytes.
  - Flags last_pend, sof_pend, eof_pend.
  - Output holding register.
- Reset: all of the above clear to 0. All outputs are 0, including pkt_i_tready and px_o_tvalid.
- pop = (cnt ≥ 5) && (!px_o_tvalid || px_o_tready). pop is evaluated on the registered cnt only.
- pkt_i_tready = !last_pend && (cnt ≤ 4 || pop). This is combinational from px_o_tready.
- accept = pkt_i_tvalid && pkt_i_tready.
- Same-cycle pop and accept:
  - The 4 new bytes append after the bytes remaining from the pop.
  - cnt_next = cnt − 5·pop + 4·accept.
- Group unpack, from bytes B0..B4:
  - Pk[9:2] = Bk, for k = 0..3.
  - Pk[1:0] = B4[2k+1:2k].
- Output register:
  - Loads on pop.
  - px_o_tvalid is set on pop.
  - px_o_tvalid is cleared on (px_o_tready && !pop).
  - Contents are held while px_o_tvalid && !px_o_tready.
- Latency: the first beat appears 1 cycle after the edge on which the second word of a line is accepted.
- Throughput: with px_o_tready held high, the input is never stalled. The block sustains 5 input words → 4 output beats.
- Line end:
  - Accepting a tlast word sets last_pend. While last_pend is set, input is blocked.
  - A pop with last_pend and (cnt − 5) < 5:
    - px_o_tlast = 1 on that beat.
    - Remaining bytes are discarded; cnt ← 0.
    - last_pend ← 0.
  - If last_pend && cnt < 5 with no pop possible:
    - Discard; cnt ← 0, last_pend ← 0.
    - Pulse short_line_o. No tlast is emitted.
- SOF:
  - frame_start_i sets sof_pend.
  - The next popped beat carries px_o_tuser = 1 and clears sof_pend.
  - frame_start_i arriving on a pop cycle applies to the next beat, not the current one.
- EOF:
  - frame_end_i sets eof_pend.
  - frame_end_o pulses for 1 cycle once eof_pend && cnt == 0 && !last_pend && !px_o_tvalid; eof_pend then clears.
- Repeated pulses: a frame_start_i while sof_pend is already set is absorbed, with no second tuser.
- Reset mid-line: all buffered bytes are lost and no partial beat is emitted.

Decomposition:
- Shared package csi2_data_types_pkg:
  - RAW10_GROUP_BYTES = 5
  - RAW10_PX_PER_GROUP = 4
  - function raw10_unpack(40-bit group) → 4×10-bit pixels
- One natural sub-module: csi2_byte_gearbox, the 4-byte-in / 5-byte-out buffer with cnt and the append/pop logic.
- The top level keeps line/frame flags and the output register.

Test Plan:
- Single group: send words 0x55AA00FF then 0x00000063 (tlast on the second), ready held 1.
  - Expect one beat P0=0x3FF, P1=0x000, P2=0x2AA, P3=0x155, with tlast=1.
  - short_line_o stays 0.
- Full line: 640 px = 800 bytes = 200 words, plus a CRC word, tlast on the last.
  - Expect 160 beats, tlast only on beat 160, pkt_i_tready never low, CRC bytes dropped.
- Backpressure: toggle px_o_tready randomly on the same line.
  - Expect beat data identical to the unstalled run and no beat lost or duplicated.
  - tdata must stay stable while valid && !ready.
- Short line: a single word with tlast.
  - Expect no output beat, short_line_o pulses once, and tready returns to 1 the next cycle.
- Frame framing: frame_start_i, then 2 lines, then frame_end_i while beats are still pending.
  - Expect tuser=1 only on the first beat of line 1.
  - frame_end_o pulses after the last beat handshake, exactly once.
- Reset mid-line: assert rst_i after 3 words.
  - Outputs go to 0 asynchronously.
  - A new line after reset unpacks correctly from byte 0.
